// File: rtl/exe_mem_req.sv
// exe_mem_req: execute-stage memory request issuer.
// Latches a load/store into holding registers and presents it on a
// req/addr_ok data SRAM interface. Store data is lane-replicated and byte
// strobes are generated. Requests accepted but not yet answered (data_ok)
// are counted, and new issue is throttled at MAX_OUTST.
// Optional feature macro: EXE_MEM_ALE_EN (address-misaligned exception).
//
// state  | meaning
// IDLE   | no request in flight for the current instruction; may latch one
// REQ    | data_sram_req high, fields held until addr_ok
// DONE   | request (or exception) finished, wait for stage advance/flush
module exe_mem_req #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 32,
   parameter int MAX_OUTST = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid_i,
   input  logic                req_we_i,
   input  logic [1:0]          req_size_i,
   input  logic [ADDR_W-1:0]   req_addr_i,
   input  logic [DATA_W-1:0]   req_wdata_i,
   input  logic                stage_advance_i,
   input  logic                flush_i,
   output logic                req_ready_go_o,
   output logic                data_sram_req_o,
   output logic                data_sram_wr_o,
   output logic [1:0]          data_sram_size_o,
   output logic [DATA_W/8-1:0] data_sram_wstrb_o,
   output logic [ADDR_W-1:0]   data_sram_addr_o,
   output logic [DATA_W-1:0]   data_sram_wdata_o,
   input  logic                data_sram_addr_ok_i,
   input  logic                data_sram_data_ok_i,
   output logic [2:0]          outst_cnt_o,
   output logic                ale_excp_o
);

   localparam int NB = DATA_W / 8;
   localparam int K  = $clog2(NB);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

   state_t              state_q, state_d;
   logic                we_q;
   logic [1:0]          size_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [NB-1:0]       wstrb_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [2:0]          cnt_q, cnt_d;
   logic                ale_q, ale_d;

   logic                misal;
   logic                latch;
   logic                ready;
   logic                ale;
   logic                inc, dec, room;
   logic [K-1:0]        off;
   logic [NB-1:0]       strb_new;
   logic [DATA_W-1:0]   wdata_new;

   assign off = req_addr_i[K-1:0];

`ifdef EXE_MEM_ALE_EN
   // Natural-alignment check for half/word/dword accesses.
   always_comb begin
      misal = 1'b0;
      case (req_size_i)
         2'b01:   misal = req_addr_i[0];
         2'b10:   misal = |req_addr_i[1:0];
         2'b11:   misal = |req_addr_i[2:0];
         default: misal = 1'b0;
      endcase
   end
`else
   assign misal = 1'b0;
`endif

   // Byte strobes and lane-replicated write data for the incoming op.
   always_comb begin
      strb_new  = '0;
      wdata_new = req_wdata_i;
      case (req_size_i)
         2'b00: begin
            strb_new  = NB'(1) << off;
            wdata_new = {NB{req_wdata_i[7:0]}};
         end
         2'b01: begin
            strb_new  = NB'(3) << (off & ~K'(1));
            wdata_new = {(NB/2){req_wdata_i[15:0]}};
         end
         2'b10: begin
            strb_new  = NB'(15) << (off & ~K'(3));
            wdata_new = {(NB/4){req_wdata_i[31:0]}};
         end
         default: begin
            strb_new  = '1;
            wdata_new = req_wdata_i;
         end
      endcase
      if (!req_we_i) strb_new = '0;
   end

   // A data_ok in the same cycle frees a slot, so IDLE may latch early.
   assign inc   = (state_q == S_REQ) & data_sram_addr_ok_i;
   assign dec   = data_sram_data_ok_i & (cnt_q != 3'd0);
   assign room  = (cnt_q < 3'(MAX_OUTST)) | dec;
   assign cnt_d = cnt_q + {2'b00, inc} - {2'b00, dec};

   // Next-state and handshake decode.
   always_comb begin
      state_d = state_q;
      latch   = 1'b0;
      ready   = 1'b0;
      ale     = 1'b0;
      ale_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!req_valid_i) begin
               ready = 1'b1;
            end else if (!flush_i) begin
               if (misal) begin
                  ready = 1'b1;
                  ale   = 1'b1;
                  if (!stage_advance_i) begin
                     ale_d   = 1'b1;
                     state_d = S_DONE;
                  end
               end else if (room) begin
                  latch   = 1'b1;
                  state_d = S_REQ;
               end
            end
         end
         S_REQ: begin
            if (data_sram_addr_ok_i) begin
               ready   = 1'b1;
               state_d = (stage_advance_i | flush_i) ? S_IDLE : S_DONE;
            end
         end
         S_DONE: begin
            ready = 1'b1;
            ale   = ale_q;
            ale_d = ale_q;
            if (stage_advance_i | flush_i) begin
               ale_d   = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, outstanding counter and request holding registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 3'd0;
         ale_q   <= 1'b0;
         we_q    <= 1'b0;
         size_q  <= 2'b00;
         addr_q  <= '0;
         wstrb_q <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ale_q   <= ale_d;
         if (latch) begin
            we_q    <= req_we_i;
            size_q  <= req_size_i;
            addr_q  <= req_addr_i;
            wstrb_q <= strb_new;
            wdata_q <= wdata_new;
         end
      end
   end

   // Handshake outputs are held low while reset is applied.
   assign req_ready_go_o    = ready & ~reset;
   assign ale_excp_o        = ale & ~reset;
   assign data_sram_req_o   = (state_q == S_REQ);
   assign data_sram_wr_o    = we_q;
   assign data_sram_size_o  = size_q;
   assign data_sram_addr_o  = addr_q;
   assign data_sram_wstrb_o = wstrb_q;
   assign data_sram_wdata_o = wdata_q;
   assign outst_cnt_o       = cnt_q;

endmodule

// File: tb/tb_exe_mem_req.sv
// Testbench for exe_mem_req (DATA_W=32, ADDR_W=32, MAX_OUTST=2).
module tb_exe_mem_req;

   localparam int MAX = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_we, stage_advance, flush;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        ready_go, sreq, swr;
   logic [1:0]  ssize;
   logic [3:0]  wstrb;
   logic [31:0] saddr, swdata;
   logic        addr_ok, data_ok;
   logic [2:0]  outst_cnt;
   logic        ale;

   int checks = 0;
   int errors = 0;
   int mcnt = 0;
   int req_total = 0;

   logic        cur_we;
   logic [1:0]  cur_size;
   logic [31:0] cur_addr, cur_wdata;

   exe_mem_req #(.DATA_W(32), .ADDR_W(32), .MAX_OUTST(MAX)) dut (
      .clk(clk), .reset(reset),
      .req_valid_i(req_valid), .req_we_i(req_we), .req_size_i(req_size),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .stage_advance_i(stage_advance), .flush_i(flush),
      .req_ready_go_o(ready_go), .data_sram_req_o(sreq), .data_sram_wr_o(swr),
      .data_sram_size_o(ssize), .data_sram_wstrb_o(wstrb),
      .data_sram_addr_o(saddr), .data_sram_wdata_o(swdata),
      .data_sram_addr_ok_i(addr_ok), .data_sram_data_ok_i(data_ok),
      .outst_cnt_o(outst_cnt), .ale_excp_o(ale)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Strobe from byte arithmetic: which bytes of the 4-byte word are touched.
   function automatic logic [31:0] m_strb(input logic we, input logic [1:0] sz, input logic [31:0] a);
      int lo;
      if (!we) return 32'd0;
      case (sz)
         2'd0: begin lo = int'(a % 4);           return 32'd1 << lo; end
         2'd1: begin lo = int'((a % 4) / 2) * 2; return 32'd3 << lo; end
         default: return 32'hF;
      endcase
   endfunction

   function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] w);
      case (sz)
         2'd0: return {24'd0, w[7:0]} * 32'h01010101;
         2'd1: return {16'd0, w[15:0]} * 32'h00010001;
         default: return w;
      endcase
   endfunction

   // Compare process: outstanding count and request fields every cycle.
   always @(negedge clk) begin
      if (reset) begin
         mcnt <= 0;
      end else begin
         chk("outst_cnt", {61'd0, outst_cnt}, 64'(mcnt));
`ifndef EXE_MEM_ALE_EN
         chk("ale_tied", {63'd0, ale}, 64'd0);
`endif
         if (sreq) begin
            req_total <= req_total + 1;
            chk("below_limit", 64'(mcnt < MAX), 64'd1);
            chk("req_addr", {32'd0, saddr}, {32'd0, cur_addr});
            chk("req_wr", {63'd0, swr}, {63'd0, cur_we});
            chk("req_size", {62'd0, ssize}, {62'd0, cur_size});
            chk("req_wstrb", {60'd0, wstrb}, {32'd0, m_strb(cur_we, cur_size, cur_addr)});
            if (cur_we) chk("req_wdata", {32'd0, swdata}, {32'd0, m_wdata(cur_size, cur_wdata)});
         end
         mcnt <= mcnt + ((sreq && addr_ok) ? 1 : 0) - ((data_ok && mcnt > 0) ? 1 : 0);
      end
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic v, input logic we, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
      req_valid = v; req_we = we; req_size = sz; req_addr = a; req_wdata = wd;
      cur_we = we; cur_size = sz; cur_addr = a; cur_wdata = wd;
   endtask

   // One op: latch cycle, (waits+1) REQ cycles with addr_ok on the last.
   task automatic do_op(input logic we, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input int waits, input logic adv,
                        input logic fl, input logic [3:0] lit_strb, input logic [31:0] lit_wd);
      int t0;
      step;
      set_op(1'b1, we, sz, a, wd);
      stage_advance = 1'b0;
      @(negedge clk);
      chk("latch_no_req", {63'd0, sreq}, 64'd0);
      t0 = req_total;
      for (int i = 0; i <= waits; i++) begin
         step;
         addr_ok       = (i == waits);
         stage_advance = adv && (i == waits);
         flush         = fl;
         @(negedge clk);
         chk("req_high", {63'd0, sreq}, 64'd1);
         chk("ready_go_req", {63'd0, ready_go}, 64'(i == waits));
         if (i == 0) begin
            chk("lit_wstrb", {60'd0, wstrb}, {60'd0, lit_strb});
            chk("lit_addr", {32'd0, saddr}, {32'd0, a});
            if (we) chk("lit_wdata", {32'd0, swdata}, {32'd0, lit_wd});
         end
      end
      step;
      addr_ok = 1'b0; stage_advance = 1'b0; flush = 1'b0;
      if (adv || fl) req_valid = 1'b0;
      @(negedge clk);
      chk("req_dropped", {63'd0, sreq}, 64'd0);
      chk("req_cycles", 64'(req_total - t0), 64'(waits + 1));
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) begin
         step;
         data_ok = 1'b1;
      end
      step;
      data_ok = 1'b0;
      @(negedge clk);
      chk("drained", {61'd0, outst_cnt}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      int t0;
      reset = 1'b1;
      set_op(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
      stage_advance = 1'b0; flush = 1'b0; addr_ok = 1'b0; data_ok = 1'b0;
      repeat (3) step;
      @(negedge clk);
      chk("rst_req", {63'd0, sreq}, 64'd0);
      chk("rst_cnt", {61'd0, outst_cnt}, 64'd0);
      chk("rst_wstrb", {60'd0, wstrb}, 64'd0);
      chk("rst_addr", {32'd0, saddr}, 64'd0);
      chk("rst_wdata", {32'd0, swdata}, 64'd0);
      chk("rst_wr", {63'd0, swr}, 64'd0);
      chk("rst_size", {62'd0, ssize}, 64'd0);
      chk("rst_ready_go", {63'd0, ready_go}, 64'd0);
      chk("rst_ale", {63'd0, ale}, 64'd0);
      step;
      reset = 1'b0;
      @(negedge clk);
      chk("idle_nonmem_ready", {63'd0, ready_go}, 64'd1);

      // st.w, addr_ok on third REQ cycle
      do_op(1'b1, 2'd2, 32'h1004, 32'hDEADBEEF, 2, 1'b1, 1'b0, 4'hF, 32'hDEADBEEF);
      chk("st_w_cnt", {61'd0, outst_cnt}, 64'd1);
      drain(1);
      // st.b and st.h lane replication
      do_op(1'b1, 2'd0, 32'h1003, 32'h000000A5, 0, 1'b1, 1'b0, 4'b1000, 32'hA5A5A5A5);
      drain(1);
      do_op(1'b1, 2'd1, 32'h1002, 32'h00001234, 1, 1'b1, 1'b0, 4'b1100, 32'h12341234);
      drain(1);
      do_op(1'b1, 2'd0, 32'h1000, 32'h0000003C, 0, 1'b1, 1'b0, 4'b0001, 32'h3C3C3C3C);
      drain(1);

      // Outstanding limit
      do_op(1'b0, 2'd2, 32'h2000, 32'd0, 0, 1'b1, 1'b0, 4'h0, 32'd0);
      do_op(1'b0, 2'd2, 32'h2004, 32'd0, 0, 1'b1, 1'b0, 4'h0, 32'd0);
      step;
      set_op(1'b1, 1'b0, 2'd2, 32'h2008, 32'd0);
      @(negedge clk);
      chk("full_no_req", {63'd0, sreq}, 64'd0);
      chk("full_ready_go", {63'd0, ready_go}, 64'd0);
      chk("full_cnt", {61'd0, outst_cnt}, 64'd2);
      step;
      data_ok = 1'b1;
      @(negedge clk);
      chk("full_no_req2", {63'd0, sreq}, 64'd0);
      chk("full_ready_go2", {63'd0, ready_go}, 64'd0);
      step;
      data_ok = 1'b0;
      @(negedge clk);
      chk("third_issue", {63'd0, sreq}, 64'd1);
      chk("third_cnt", {61'd0, outst_cnt}, 64'd1);
      step;
      addr_ok = 1'b1; stage_advance = 1'b1; data_ok = 1'b1;
      @(negedge clk);
      chk("third_ready_go", {63'd0, ready_go}, 64'd1);
      step;
      addr_ok = 1'b0; stage_advance = 1'b0; data_ok = 1'b0; req_valid = 1'b0;
      @(negedge clk);
      chk("ok_and_dok_cnt", {61'd0, outst_cnt}, 64'd1);
      drain(1);

      // Stall after addr_ok: DONE holds, no reissue
      do_op(1'b1, 2'd2, 32'h3000, 32'hCAFEF00D, 0, 1'b0, 1'b0, 4'hF, 32'hCAFEF00D);
      t0 = req_total;
      for (int i = 0; i < 3; i++) begin
         step;
         @(negedge clk);
         chk("stall_no_req", {63'd0, sreq}, 64'd0);
         chk("stall_ready_go", {63'd0, ready_go}, 64'd1);
      end
      step;
      stage_advance = 1'b1;
      @(negedge clk);
      chk("stall_release_ready", {63'd0, ready_go}, 64'd1);
      step;
      stage_advance = 1'b0; req_valid = 1'b0;
      @(negedge clk);
      chk("stall_single_req", 64'(req_total - t0), 64'd0);
      drain(1);

      // Flush in IDLE: nothing issued
      step;
      set_op(1'b1, 1'b1, 2'd0, 32'h5000, 32'h11);
      flush = 1'b1;
      @(negedge clk);
      chk("flush_idle_req", {63'd0, sreq}, 64'd0);
      step;
      @(negedge clk);
      chk("flush_idle_req2", {63'd0, sreq}, 64'd0);
      step;
      flush = 1'b0; req_valid = 1'b0;
      @(negedge clk);
      chk("flush_idle_req3", {63'd0, sreq}, 64'd0);
      chk("flush_idle_cnt", {61'd0, outst_cnt}, 64'd0);

      // Flush during REQ: held to addr_ok, then IDLE (next op latches at once)
      do_op(1'b0, 2'd0, 32'h4001, 32'd0, 1, 1'b0, 1'b1, 4'h0, 32'd0);
      do_op(1'b0, 2'd2, 32'h4004, 32'd0, 0, 1'b1, 1'b0, 4'h0, 32'd0);
      chk("flush_req_cnt", {61'd0, outst_cnt}, 64'd2);
      drain(2);

      // data_ok with nothing outstanding is ignored
      step;
      data_ok = 1'b1;
      step;
      data_ok = 1'b0;
      @(negedge clk);
      chk("no_underflow", {61'd0, outst_cnt}, 64'd0);

`ifdef EXE_MEM_ALE_EN
      step;
      set_op(1'b1, 1'b0, 2'd2, 32'h1002, 32'd0);
      @(negedge clk);
      chk("ale_set", {63'd0, ale}, 64'd1);
      chk("ale_ready_go", {63'd0, ready_go}, 64'd1);
      step;
      @(negedge clk);
      chk("ale_no_req", {63'd0, sreq}, 64'd0);
      chk("ale_held", {63'd0, ale}, 64'd1);
      step;
      stage_advance = 1'b1;
      step;
      stage_advance = 1'b0; req_valid = 1'b0;
      @(negedge clk);
      chk("ale_cnt", {61'd0, outst_cnt}, 64'd0);
`else
      // Misaligned word passes through with address unmasked
      do_op(1'b0, 2'd2, 32'h1002, 32'd0, 0, 1'b1, 1'b0, 4'h0, 32'd0);
      drain(1);
`endif

      // Reset in the middle of a request abandons it
      step;
      set_op(1'b1, 1'b1, 2'd2, 32'h6000, 32'h55AA55AA);
      step;
      @(negedge clk);
      chk("pre_reset_req", {63'd0, sreq}, 64'd1);
      step;
      reset = 1'b1; req_valid = 1'b0;
      step;
      reset = 1'b0;
      @(negedge clk);
      chk("post_reset_req", {63'd0, sreq}, 64'd0);
      chk("post_reset_cnt", {61'd0, outst_cnt}, 64'd0);
      step;
      step;
      @(negedge clk);
      chk("post_reset_quiet", {63'd0, sreq}, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
